pipeline_stall_sequencer: RTL and testbench

//  Central stall/flush sequencer for the 5-stage MIPS pipeline. Registers the pipeline-control state.

---
 rtl/pipeline_ctrl_pkg.sv | 17 +
 rtl/mem_wait_watchdog.sv | 30 +++
 rtl/pipeline_stall_sequencer.sv | 151 +++++++++++++++
 tb/tb_pipeline_stall_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared pipeline-control encodings: sequencer states and stall polarity.
// Imported by the stall sequencer and the hazard/forwarding unit.
package pipeline_ctrl_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        S_RUN      = 2'b00,
        S_MEM_WAIT = 2'b01,
        S_ERROR    = 2'b10
    } pipeState_t;

    // Stall-enable polarity: 1 lets a pipeline register advance, 0 holds it.
    localparam logic ADVANCE = 1'b1;
    localparam logic HOLD    = 1'b0;

endpackage

// File: rtl/mem_wait_watchdog.sv
// Counts consecutive memory-wait cycles; expired flags the timeout limit.
module mem_wait_watchdog #(
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned TO_W        = 7
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam logic [TO_W-1:0] LIMIT = TO_W'(MEM_TIMEOUT);

    logic [TO_W-1:0] count;

    // clear together with inc restarts the count at 1 (first wait cycle).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= inc ? TO_W'(1) : '0;
        end else if (inc && (count != '1)) begin
            count <= count + TO_W'(1);
        end
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/pipeline_stall_sequencer.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Optional statistics counters are built when STALL_STATS_EN is defined.
module pipeline_stall_sequencer
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned TO_W        = 7,
    parameter int unsigned DELAY_SLOT  = 1,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             loadUse,
    input  logic             memReq,
    input  logic             memReady,
    input  logic             branchTaken,
    output logic             stallPC,
    output logic             stallNPC,
    output logic             stallIFID,
    output logic             controlMux,
    output logic             flushIFID,
    output logic             pipeHold,
    output logic             memTimeout,
    output logic [CNT_W-1:0] bubbleCnt,
    output logic [CNT_W-1:0] memWaitCnt,
    output logic [CNT_W-1:0] flushCnt
);

    pipeState_t state;
    pipeState_t stateNext;
    logic       wdClear;
    logic       wdInc;
    logic       wdExpired;

    mem_wait_watchdog #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .TO_W        (TO_W)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (wdClear),
        .inc     (wdInc),
        .expired (wdExpired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_RUN;
        end else begin
            state <= stateNext;
        end
    end

    // Outputs decode state plus live requests; reset forces the free-running values.
    always_comb begin
        stateNext  = state;
        wdClear    = 1'b0;
        wdInc      = 1'b0;
        stallPC    = ADVANCE;
        stallNPC   = ADVANCE;
        stallIFID  = ADVANCE;
        controlMux = 1'b0;
        flushIFID  = 1'b0;
        pipeHold   = 1'b0;
        memTimeout = 1'b0;

        if (rst_n) begin
            unique case (state)
                S_RUN: begin
                    if (memReq && !memReady) begin
                        stallPC   = HOLD;
                        stallNPC  = HOLD;
                        stallIFID = HOLD;
                        pipeHold  = 1'b1;
                        wdClear   = 1'b1;
                        wdInc     = 1'b1;
                        stateNext = S_MEM_WAIT;
                    end else if (loadUse) begin
                        // Branch alongside loadUse re-presents next cycle since ID is held.
                        stallPC    = HOLD;
                        stallNPC   = HOLD;
                        stallIFID  = HOLD;
                        controlMux = 1'b1;
                    end else if (branchTaken && (DELAY_SLOT == 0)) begin
                        flushIFID = 1'b1;
                    end
                end

                S_MEM_WAIT: begin
                    if (memReady) begin
                        wdClear   = 1'b1;
                        stateNext = S_RUN;
                    end else begin
                        stallPC   = HOLD;
                        stallNPC  = HOLD;
                        stallIFID = HOLD;
                        pipeHold  = 1'b1;
                        if (wdExpired) begin
                            wdClear   = 1'b1;
                            stateNext = S_ERROR;
                        end else begin
                            wdInc = 1'b1;
                        end
                    end
                end

                S_ERROR: begin
                    stallPC    = HOLD;
                    stallNPC   = HOLD;
                    stallIFID  = HOLD;
                    pipeHold   = 1'b1;
                    memTimeout = 1'b1;
                end

                default: begin
                    stateNext = S_RUN;
                end
            endcase
        end
    end

`ifdef STALL_STATS_EN
    logic memWaitEvt;

    assign memWaitEvt = pipeHold && (state == S_MEM_WAIT);

    // Saturating event counters; they stick at all-ones rather than wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubbleCnt  <= '0;
            memWaitCnt <= '0;
            flushCnt   <= '0;
        end else begin
            if (controlMux && (bubbleCnt != '1)) begin
                bubbleCnt <= bubbleCnt + CNT_W'(1);
            end
            if (memWaitEvt && (memWaitCnt != '1)) begin
                memWaitCnt <= memWaitCnt + CNT_W'(1);
            end
            if (flushIFID && (flushCnt != '1)) begin
                flushCnt <= flushCnt + CNT_W'(1);
            end
        end
    end
`else
    assign bubbleCnt  = '0;
    assign memWaitCnt = '0;
    assign flushCnt   = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_sequencer.sv
// Scoreboard bench for pipeline_stall_sequencer: directed scenarios then random traffic.
module tb_pipeline_stall_sequencer;

    localparam int unsigned MEM_TIMEOUT = 8;
    localparam int unsigned TO_W        = 4;
    localparam int unsigned DELAY_SLOT  = 0;
    localparam int unsigned CNT_W       = 16;
    localparam int          CNT_MAX     = (1 << CNT_W) - 1;
`ifdef STALL_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    typedef struct packed {
        logic             stallPC;
        logic             stallNPC;
        logic             stallIFID;
        logic             controlMux;
        logic             flushIFID;
        logic             pipeHold;
        logic             memTimeout;
        logic [CNT_W-1:0] bubbleCnt;
        logic [CNT_W-1:0] memWaitCnt;
        logic [CNT_W-1:0] flushCnt;
    } expect_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             loadUse = 1'b0;
    logic             memReq = 1'b0;
    logic             memReady = 1'b0;
    logic             branchTaken = 1'b0;
    logic             stallPC, stallNPC, stallIFID;
    logic             controlMux, flushIFID, pipeHold, memTimeout;
    logic [CNT_W-1:0] bubbleCnt, memWaitCnt, flushCnt;

    expect_t expQ[$];
    int      total = 0;
    int      bad = 0;

    // Reference model: an outstanding access, its consecutive unready cycles, and a dead flag.
    bit mWaiting = 1'b0;
    bit mDead = 1'b0;
    int mUnready = 0;
    int mBubbles = 0;
    int mWaits = 0;
    int mFlushes = 0;

    pipeline_stall_sequencer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .TO_W        (TO_W),
        .DELAY_SLOT  (DELAY_SLOT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .loadUse     (loadUse),
        .memReq      (memReq),
        .memReady    (memReady),
        .branchTaken (branchTaken),
        .stallPC     (stallPC),
        .stallNPC    (stallNPC),
        .stallIFID   (stallIFID),
        .controlMux  (controlMux),
        .flushIFID   (flushIFID),
        .pipeHold    (pipeHold),
        .memTimeout  (memTimeout),
        .bubbleCnt   (bubbleCnt),
        .memWaitCnt  (memWaitCnt),
        .flushCnt    (flushCnt)
    );

    always #5 clk = ~clk;

    function automatic int sat(input int n);
        return (n < CNT_MAX) ? n + 1 : n;
    endfunction

    function automatic logic [CNT_W-1:0] cntView(input int n);
        return STATS_ON ? CNT_W'(n) : '0;
    endfunction

    function automatic expect_t frozen(input expect_t e);
        expect_t f = e;
        f.stallPC   = 1'b0;
        f.stallNPC  = 1'b0;
        f.stallIFID = 1'b0;
        f.pipeHold  = 1'b1;
        return f;
    endfunction

    // Drive one cycle and queue what the DUT must show during it.
    task automatic step(input bit r, input bit lu, input bit mq, input bit mr, input bit br);
        expect_t e;
        @(negedge clk);
        rst_n       = r;
        loadUse     = lu;
        memReq      = mq;
        memReady    = mr;
        branchTaken = br;
        if (!r) begin
            mWaiting = 1'b0;
            mDead    = 1'b0;
            mUnready = 0;
            mBubbles = 0;
            mWaits   = 0;
            mFlushes = 0;
        end
        e            = '0;
        e.stallPC    = 1'b1;
        e.stallNPC   = 1'b1;
        e.stallIFID  = 1'b1;
        e.bubbleCnt  = cntView(mBubbles);
        e.memWaitCnt = cntView(mWaits);
        e.flushCnt   = cntView(mFlushes);
        if (r) begin
            if (mDead) begin
                e            = frozen(e);
                e.memTimeout = 1'b1;
            end else if (mWaiting) begin
                if (mr) begin
                    mWaiting = 1'b0;
                end else begin
                    e     = frozen(e);
                    mWaits = sat(mWaits);
                    if (mUnready == int'(MEM_TIMEOUT)) begin
                        mDead    = 1'b1;
                        mWaiting = 1'b0;
                    end else begin
                        mUnready++;
                    end
                end
            end else if (mq && !mr) begin
                e        = frozen(e);
                mWaiting = 1'b1;
                mUnready = 1;
            end else if (lu) begin
                e.stallPC    = 1'b0;
                e.stallNPC   = 1'b0;
                e.stallIFID  = 1'b0;
                e.controlMux = 1'b1;
                mBubbles     = sat(mBubbles);
            end else if (br && (DELAY_SLOT == 0)) begin
                e.flushIFID = 1'b1;
                mFlushes    = sat(mFlushes);
            end
        end
        expQ.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, want);
        end
    endtask

    // Monitor: pops one expectation per cycle and compares after outputs settle.
    always @(negedge clk) begin
        expect_t e;
        #2;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            check("stallPC",    32'(stallPC),    32'(e.stallPC));
            check("stallNPC",   32'(stallNPC),   32'(e.stallNPC));
            check("stallIFID",  32'(stallIFID),  32'(e.stallIFID));
            check("controlMux", 32'(controlMux), 32'(e.controlMux));
            check("flushIFID",  32'(flushIFID),  32'(e.flushIFID));
            check("pipeHold",   32'(pipeHold),   32'(e.pipeHold));
            check("memTimeout", 32'(memTimeout), 32'(e.memTimeout));
            check("bubbleCnt",  32'(bubbleCnt),  32'(e.bubbleCnt));
            check("memWaitCnt", 32'(memWaitCnt), 32'(e.memWaitCnt));
            check("flushCnt",   32'(flushCnt),   32'(e.flushCnt));
        end
    end

    initial begin
        #2000000;
        $display("FAIL runaway: simulation exceeded time bound");
        $fatal(1, "time bound expired");
    end

    initial begin
        // Reset held with noisy requests
        step(0, 1, 1, 0, 1);
        step(0, 0, 1, 0, 0);
        step(0, 1, 0, 1, 1);
        // Single load-use bubble
        step(1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        // Four unready cycles then ready
        repeat (4) step(1, 0, 1, 0, 0);
        step(1, 0, 1, 1, 0);
        step(1, 0, 0, 0, 0);
        // loadUse with branch, then branch alone flushes
        step(1, 1, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0);
        // Requests ignored while waiting
        step(1, 0, 1, 0, 0);
        step(1, 1, 1, 0, 1);
        step(1, 1, 1, 1, 1);
        // Watchdog timeout, sticky until reset
        repeat (MEM_TIMEOUT + 4) step(1, 0, 1, 0, 0);
        step(1, 1, 0, 1, 1);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        // Reset mid-wait
        repeat (3) step(1, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1);

        for (int ph = 0; ph < 8; ph++) begin
            int readyPct;
            readyPct = (ph % 2 == 1) ? 8 : 60;
            for (int i = 0; i < 250; i++) begin
                step($urandom_range(0, 99) >= 2,
                     $urandom_range(0, 99) < 25,
                     $urandom_range(0, 99) < 40,
                     $urandom_range(0, 99) < readyPct,
                     $urandom_range(0, 99) < 30);
            end
        end

        repeat (3) @(negedge clk);
        #5;
        total++;
        if (expQ.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", expQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
